serial_frame_receiver: RTL and testbench

- Downstream consumer of the memory read-out stage's serial stream (transfer bit plus its clock), sitting on the receiving board.
- Synchronises the serial clock, data and enable into the local clk domain and deserialises 8-bit bytes, LSB first.
- Buffers bytes in a small FIFO and presents them on a valid/ready interface.
- Counts bytes per frame and flags completion, short frames and overflow.

---
 rtl/serial_frame_receiver.sv | 170 +++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: synchronises an upstream bit-serial stream, deserialises bytes into a FIFO.
// Define SERIAL_RX_MSB_FIRST_EN to place the first sampled bit in bit 7 instead of bit 0.
module serial_frame_receiver #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ser_clk,
    input  logic                          ser_data,
    input  logic                          ser_en,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t state, stateNext;

    logic serClkMeta, serClkS, clkD;
    logic serDataMeta, serDataS;
    logic serEnMeta, serEnS, serEnD;
    logic [1:0] primeSr;
    logic strobe, serEnRise;

    logic [2:0] bitCnt;
    logic [7:0] byteCnt;
    logic [7:0] shiftReg, assembled;
    logic lastByte;
    logic clrCnt, shiftEn, pushEn, doneSet, errSet;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] memCount;
    logic          headValid;
    logic [7:0]    headData;
    logic          full, pop, pushOk, load;

    // serEnD holds 1 until the synchroniser has flushed, so an enable already high at reset is not a rise
    always_ff @(posedge clk) begin
        if (reset) begin
            serClkMeta  <= 1'b0;
            serClkS     <= 1'b0;
            clkD        <= 1'b0;
            serDataMeta <= 1'b0;
            serDataS    <= 1'b0;
            serEnMeta   <= 1'b0;
            serEnS      <= 1'b0;
            serEnD      <= 1'b1;
            primeSr     <= '0;
        end else begin
            serClkMeta  <= ser_clk;
            serClkS     <= serClkMeta;
            clkD        <= serClkS;
            serDataMeta <= ser_data;
            serDataS    <= serDataMeta;
            serEnMeta   <= ser_en;
            serEnS      <= serEnMeta;
            primeSr     <= {primeSr[0], 1'b1};
            serEnD      <= primeSr[1] ? serEnS : 1'b1;
        end
    end

    assign strobe    = serClkS & ~clkD & serEnS;
    assign serEnRise = serEnS & ~serEnD;
    assign lastByte  = (byteCnt == 8'(FRAME_LEN - 1));

    always_comb begin
        assembled = shiftReg;
`ifdef SERIAL_RX_MSB_FIRST_EN
        assembled[3'd7 - bitCnt] = serDataS;
`else
        assembled[bitCnt] = serDataS;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (serEnRise) stateNext = RECV;
            RECV: begin
                if (!serEnS)
                    stateNext = IDLE;
                else if (strobe && bitCnt == 3'd7 && lastByte)
                    stateNext = DONE;
            end
            DONE: if (!serEnS) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        clrCnt  = (state == IDLE) && serEnRise;
        shiftEn = (state == RECV) && strobe;
        pushEn  = shiftEn && (bitCnt == 3'd7);
        doneSet = pushEn && lastByte;
        errSet  = (state == RECV) && !serEnS;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitCnt     <= '0;
            byteCnt    <= '0;
            shiftReg   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= doneSet;
            frame_err  <= errSet;
            if (clrCnt || errSet) begin
                bitCnt <= '0;
                if (clrCnt) byteCnt <= '0;
            end else if (shiftEn) begin
                shiftReg <= assembled;
                bitCnt   <= bitCnt + 3'd1;
                if (pushEn) byteCnt <= byteCnt + 8'd1;
            end
            if (pushEn && full && !pop) overflow <= 1'b1;
        end
    end

    // Storage feeds a registered head stage; fifo_count covers both so the head counts as held
    assign pop        = headValid & out_ready;
    assign fifo_count = memCount + CW'(headValid);
    assign full       = (fifo_count == CW'(FIFO_DEPTH));
    assign pushOk     = pushEn & (~full | pop);
    assign load       = (memCount != '0) & (~headValid | pop);

    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr] <= assembled;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            memCount  <= '0;
            headValid <= 1'b0;
            headData  <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + AW'(1);
            if (load) begin
                headData  <= mem[rdPtr];
                headValid <= 1'b1;
                rdPtr     <= rdPtr + AW'(1);
            end else if (pop) begin
                headData  <= '0;
                headValid <= 1'b0;
            end
            memCount <= memCount + CW'(pushOk) - CW'(load);
        end
    end

    assign out_data  = headData;
    assign out_valid = headValid;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver with immediate-assertion checks.
// Honours SERIAL_RX_MSB_FIRST_EN when computing expected bytes.
module tb_serial_frame_receiver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_clk = 1'b0;
    logic       ser_data = 1'b0;
    logic       ser_en = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [4:0] fifo_count;
    logic       frame_done, frame_err, overflow;

    int vectors = 0;
    int miscompares = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int d0, e0;
    logic [7:0] rx[$];
    logic [7:0] expList[$];

    always #5 clk = ~clk;

    serial_frame_receiver #(.FIFO_DEPTH(16), .FRAME_LEN(10)) dut (
        .clk(clk), .reset(reset), .ser_clk(ser_clk), .ser_data(ser_data), .ser_en(ser_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow)
    );

    always @(negedge clk) begin
        if (frame_done) doneCnt++;
        if (frame_err) errCnt++;
        if (out_valid && out_ready) rx.push_back(out_data);
    end

    function automatic logic [7:0] expByte(input logic [7:0] b);
        logic [7:0] r;
`ifdef SERIAL_RX_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBit(input logic b);
        ser_data = b;
        ser_clk = 1'b0;
        tick(4);
        ser_clk = 1'b1;
        tick(4);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
    endtask

    task automatic startFrame();
        ser_en = 1'b1;
        tick(4);
    endtask

    task automatic endFrame();
        ser_clk = 1'b0;
        tick(4);
        ser_en = 1'b0;
        tick(6);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (fifo_count != 0 || out_valid); i++) tick(1);
        out_ready = 1'b0;
        tick(2);
        check("drain_empty", {27'd0, fifo_count}, 32'd0);
    endtask

    task automatic checkRx(input string tag);
        check($sformatf("%s_count", tag), rx.size(), expList.size());
        for (int i = 0; i < expList.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), (i < rx.size()) ? {24'd0, rx[i]} : 32'hDEAD, {24'd0, expList[i]});
    endtask

    initial begin
        // reset state
        applyReset();
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data", out_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);

        // full frame 0x01..0x0A with consumer ready
        out_ready = 1'b1;
        d0 = doneCnt; e0 = errCnt;
        rx.delete(); expList.delete();
        startFrame();
        for (int i = 1; i <= 10; i++) begin
            sendByte(8'(i));
            expList.push_back(expByte(8'(i)));
        end
        endFrame();
        tick(4);
        checkRx("frameA");
        check("frameA_done", doneCnt - d0, 1);
        check("frameA_err", errCnt - e0, 0);
        check("frameA_ovf", overflow, 0);
        out_ready = 1'b0;

        // latency and hold of a single byte 0xA5
        applyReset();
        startFrame();
        for (int i = 0; i < 7; i++) sendBit(1'((8'hA5 >> i) & 8'h01));
        ser_data = 1'b1;
        ser_clk = 1'b0;
        tick(4);
        ser_clk = 1'b1;
        tick(3);
        check("lat_valid_p3", out_valid, 0);
        check("lat_count_p3", fifo_count, 1);
        tick(1);
        check("lat_valid_p4", out_valid, 1);
        check("lat_data", out_data, expByte(8'hA5));
        tick(5);
        check("hold_data", out_data, expByte(8'hA5));
        check("hold_count", fifo_count, 1);
        e0 = errCnt;
        ser_clk = 1'b0;
        tick(4);
        ser_en = 1'b0;
        tick(6);
        check("short_err", errCnt - e0, 1);
        check("short_keep", fifo_count, 1);

        // two frames into a 16-deep FIFO with no consumer
        applyReset();
        d0 = doneCnt;
        startFrame();
        for (int i = 0; i < 10; i++) sendByte(8'(8'h10 + i));
        endFrame();
        startFrame();
        for (int i = 10; i < 20; i++) sendByte(8'(8'h10 + i));
        endFrame();
        check("ovf_count", fifo_count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_done", doneCnt - d0, 2);
        rx.delete(); expList.delete();
        for (int i = 0; i < 16; i++) expList.push_back(expByte(8'(8'h10 + i)));
        drain();
        checkRx("ovf_drain");
        check("ovf_sticky", overflow, 1);

        // reset mid-byte with 5 bytes held and ser_en still high
        startFrame();
        for (int i = 0; i < 5; i++) sendByte(8'(8'h50 + i));
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
        check("mid_count_pre", fifo_count, 5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_count", fifo_count, 0);
        check("mid_valid", out_valid, 0);
        check("mid_ovf", overflow, 0);
        check("mid_data", out_data, 0);
        tick(4);
        sendByte(8'h77);
        tick(6);
        check("en_high_ignored", fifo_count, 0);
        ser_clk = 1'b0;
        ser_en = 1'b0;
        tick(6);
        d0 = doneCnt;
        rx.delete(); expList.delete();
        out_ready = 1'b1;
        startFrame();
        for (int i = 0; i < 10; i++) begin
            sendByte(8'(8'h60 + i));
            expList.push_back(expByte(8'(8'h60 + i)));
        end
        endFrame();
        tick(4);
        checkRx("after_rst");
        check("after_rst_done", doneCnt - d0, 1);
        out_ready = 1'b0;

        // enable dropped after 3 bytes + 5 bits, then a clean frame
        d0 = doneCnt; e0 = errCnt;
        startFrame();
        for (int i = 0; i < 3; i++) sendByte(8'(8'h31 + i));
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
        ser_en = 1'b0;
        tick(6);
        check("abort_count", fifo_count, 3);
        check("abort_err", errCnt - e0, 1);
        check("abort_done", doneCnt - d0, 0);
        startFrame();
        for (int i = 0; i < 10; i++) sendByte(8'(8'h40 + i));
        endFrame();
        check("resume_count", fifo_count, 13);
        check("resume_done", doneCnt - d0, 1);
        rx.delete(); expList.delete();
        for (int i = 0; i < 3; i++) expList.push_back(expByte(8'(8'h31 + i)));
        for (int i = 0; i < 10; i++) expList.push_back(expByte(8'(8'h40 + i)));
        drain();
        checkRx("resume");

        // bit order: 1 followed by seven 0s
        applyReset();
        startFrame();
        sendBit(1'b1);
        for (int i = 0; i < 7; i++) sendBit(1'b0);
        tick(4);
`ifdef SERIAL_RX_MSB_FIRST_EN
        check("bit_order", out_data, 8'h80);
`else
        check("bit_order", out_data, 8'h01);
`endif
        ser_clk = 1'b0;
        tick(4);
        ser_en = 1'b0;
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
